// File: rtl/pc_branch_if.sv
// Operand/result bundle for the branch-target adder.
// master drives the PC and offset; slave (the adder) returns target and status.
interface pc_branch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_1_PC_Branch;
  logic [WIDTH-1:0] in_2_PC_Branch;
  logic             in_valid_PC_Branch;
  logic [WIDTH-1:0] out_PC_Branch;
  logic [WIDTH-1:0] out_q_PC_Branch;
  logic             out_valid_PC_Branch;
  logic             out_misaligned_PC_Branch;
  logic             out_wrap_PC_Branch;

  modport master (
    output in_1_PC_Branch,
    output in_2_PC_Branch,
    output in_valid_PC_Branch,
    input  out_PC_Branch,
    input  out_q_PC_Branch,
    input  out_valid_PC_Branch,
    input  out_misaligned_PC_Branch,
    input  out_wrap_PC_Branch
  );

  modport slave (
    input  in_1_PC_Branch,
    input  in_2_PC_Branch,
    input  in_valid_PC_Branch,
    output out_PC_Branch,
    output out_q_PC_Branch,
    output out_valid_PC_Branch,
    output out_misaligned_PC_Branch,
    output out_wrap_PC_Branch
  );
endinterface

// File: rtl/pc_branch.sv
// Branch-target adder: PC + offset combinationally (0 cycles), registered copy with flags (1 cycle).
// No backpressure: every edge with in_valid captures; without it out_valid drops and data holds.
module pc_branch #(
  parameter int WIDTH  = 32,
  parameter int IALIGN = 4
) (
  input logic       clk,
  input logic       rst,
  pc_branch_if.slave bus
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             misaligned_next;
  logic             wrap_next;

  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             misaligned_r;
  logic             wrap_r;

  always_comb begin
    sum_ext = {1'b0, bus.in_1_PC_Branch} + {1'b0, bus.in_2_PC_Branch};
  end

  assign sum   = sum_ext[WIDTH-1:0];
  assign carry = sum_ext[WIDTH];

  // Only 2- and 4-byte alignment exist; anything other than 2 is treated as 4.
  generate
    if (IALIGN == 2) begin : g_align2
      assign misaligned_next = sum[0];
    end else begin : g_align4
      assign misaligned_next = |sum[1:0];
    end
  endgenerate

  // A forward offset should not carry, a backward one must: any disagreement is a wrap.
  assign wrap_next = bus.in_2_PC_Branch[WIDTH-1] ^ carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r          <= '0;
      valid_r      <= 1'b0;
      misaligned_r <= 1'b0;
      wrap_r       <= 1'b0;
    end else if (bus.in_valid_PC_Branch) begin
      q_r          <= sum;
      valid_r      <= 1'b1;
      misaligned_r <= misaligned_next;
      wrap_r       <= wrap_next;
    end else begin
      valid_r      <= 1'b0;
    end
  end

  assign bus.out_PC_Branch            = sum;
  assign bus.out_q_PC_Branch          = q_r;
  assign bus.out_valid_PC_Branch      = valid_r;
  assign bus.out_misaligned_PC_Branch = misaligned_r;
  assign bus.out_wrap_PC_Branch       = wrap_r;

endmodule

// File: tb/tb_pc_branch.sv
// Bench for pc_branch: directed plan cases then random operands against an arithmetic model,
// driving an IALIGN=4 and an IALIGN=2 instance with identical operands.
module tb_pc_branch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_branch_if #(.WIDTH(32)) bus4 ();
  pc_branch_if #(.WIDTH(32)) bus2 ();

  pc_branch #(.WIDTH(32), .IALIGN(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  pc_branch #(.WIDTH(32), .IALIGN(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Expected registered state
  logic [31:0] exp_q;
  logic        exp_v, exp_m4, exp_m2, exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Target as a true signed integer; wrap means it left [0, 2^32).
  task automatic model(input logic [31:0] a, input logic [31:0] b, input int ialign,
                       output logic [31:0] s, output logic m, output logic w);
    longint t;
    t = longint'(a) + longint'($signed(b));
    s = t[31:0];
    w = (t < 0) || (t > longint'(32'hFFFF_FFFF));
    m = (s % ialign) != 0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
    bus4.in_1_PC_Branch     = a;
    bus4.in_2_PC_Branch     = b;
    bus4.in_valid_PC_Branch = v;
    bus2.in_1_PC_Branch     = a;
    bus2.in_2_PC_Branch     = b;
    bus2.in_valid_PC_Branch = v;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " q4"}, bus4.out_q_PC_Branch, exp_q);
    check({tag, " v4"}, 32'(bus4.out_valid_PC_Branch), 32'(exp_v));
    check({tag, " m4"}, 32'(bus4.out_misaligned_PC_Branch), 32'(exp_m4));
    check({tag, " w4"}, 32'(bus4.out_wrap_PC_Branch), 32'(exp_w));
    check({tag, " q2"}, bus2.out_q_PC_Branch, exp_q);
    check({tag, " v2"}, 32'(bus2.out_valid_PC_Branch), 32'(exp_v));
    check({tag, " m2"}, 32'(bus2.out_misaligned_PC_Branch), 32'(exp_m2));
    check({tag, " w2"}, 32'(bus2.out_wrap_PC_Branch), 32'(exp_w));
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v, input string tag);
    logic [31:0] s;
    logic m4, m2, w;
    @(negedge clk);
    drive(a, b, v);
    #1;
    model(a, b, 4, s, m4, w);
    model(a, b, 2, s, m2, w);
    check({tag, " comb4"}, bus4.out_PC_Branch, s);
    check({tag, " comb2"}, bus2.out_PC_Branch, s);
    @(posedge clk);
    if (v) begin
      exp_q  = s;
      exp_v  = 1'b1;
      exp_m4 = m4;
      exp_m2 = m2;
      exp_w  = w;
    end else begin
      exp_v  = 1'b0;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        v;

    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0);
    exp_q = '0; exp_v = 1'b0; exp_m4 = 1'b0; exp_m2 = 1'b0; exp_w = 1'b0;
    #2;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    step(32'd4, 32'd8, 1'b1, "basic");
    check("basic comb const", bus4.out_PC_Branch, 32'd12);
    check("basic q const", bus4.out_q_PC_Branch, 32'd12);

    step(32'd100, 32'd24, 1'b1, "add2");
    check("add2 q const", bus4.out_q_PC_Branch, 32'd124);

    step(32'd0, 32'd0, 1'b1, "zero");
    check("zero q const", bus4.out_q_PC_Branch, 32'd0);

    step(32'd100, 32'hFFFF_FFFC, 1'b1, "neg");
    check("neg q const", bus4.out_q_PC_Branch, 32'd96);
    check("neg wrap const", 32'(bus4.out_wrap_PC_Branch), 32'd0);

    step(32'hFFFF_FFFC, 32'd8, 1'b1, "wrap_up");
    check("wrap_up q const", bus4.out_q_PC_Branch, 32'd4);
    check("wrap_up wrap const", 32'(bus4.out_wrap_PC_Branch), 32'd1);

    step(32'd0, 32'hFFFF_FFFC, 1'b1, "wrap_dn");
    check("wrap_dn q const", bus4.out_q_PC_Branch, 32'hFFFF_FFFC);
    check("wrap_dn wrap const", 32'(bus4.out_wrap_PC_Branch), 32'd1);

    step(32'd100, 32'd2, 1'b1, "misal");
    check("misal q const", bus4.out_q_PC_Branch, 32'd102);
    check("misal m4 const", 32'(bus4.out_misaligned_PC_Branch), 32'd1);
    check("misal m2 const", 32'(bus2.out_misaligned_PC_Branch), 32'd0);

    step(32'd40, 32'd1, 1'b0, "novalid");
    check("novalid v const", 32'(bus4.out_valid_PC_Branch), 32'd0);
    check("novalid q hold", bus4.out_q_PC_Branch, 32'd102);

    step(32'd200, 32'd3, 1'b1, "odd");

    // Asynchronous reset between edges
    @(negedge clk);
    drive(32'd5, 32'd7, 1'b1);
    rst = 1'b1;
    #1;
    exp_q = '0; exp_v = 1'b0; exp_m4 = 1'b0; exp_m2 = 1'b0; exp_w = 1'b0;
    check_regs("midrst");
    check("midrst comb const", bus4.out_PC_Branch, 32'd12);
    #2;
    rst = 1'b0;

    step(32'd64, 32'd16, 1'b1, "postrst");
    check("postrst q const", bus4.out_q_PC_Branch, 32'd80);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 4096));
        2: b = 32'(-$signed(32'($urandom_range(0, 4096))));
        default: begin
          a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
          b = 32'($urandom_range(0, 8192));
        end
      endcase
      v = ($urandom_range(0, 3) != 0);
      step(a, b, v, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
